// File: rtl/tl_ahb_pkg.sv
// Shared constants, types and mask decoding for the TL-UL to AHB-Lite bridge.
package tl_ahb_pkg;

    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } bridge_state_e;

    typedef struct packed {
        logic       legal;
        logic [2:0] size;
        logic [1:0] lo;
    } mask_decode_t;

    // Only naturally aligned byte, half-word and word lane groups map onto one AHB beat.
    function automatic mask_decode_t mask_to_size(input logic [3:0] mask);
        mask_decode_t r;
        r = '{legal: 1'b0, size: HSIZE_BYTE, lo: 2'd0};
        case (mask)
            4'hF: r = '{legal: 1'b1, size: HSIZE_WORD, lo: 2'd0};
            4'h3: r = '{legal: 1'b1, size: HSIZE_HALF, lo: 2'd0};
            4'hC: r = '{legal: 1'b1, size: HSIZE_HALF, lo: 2'd2};
            4'h1: r = '{legal: 1'b1, size: HSIZE_BYTE, lo: 2'd0};
            4'h2: r = '{legal: 1'b1, size: HSIZE_BYTE, lo: 2'd1};
            4'h4: r = '{legal: 1'b1, size: HSIZE_BYTE, lo: 2'd2};
            4'h8: r = '{legal: 1'b1, size: HSIZE_BYTE, lo: 2'd3};
            default: r = '{legal: 1'b0, size: HSIZE_BYTE, lo: 2'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tl_to_ahb_bridge_if.sv
// TL-UL A/D channels plus AHB-Lite master signals of the bridge.
// The slave modport is the bridge's view (TL slave, AHB master); master is the surrounding system.
interface tl_to_ahb_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int SRC_W  = 4
);
    logic              tl_a_valid;
    logic              tl_a_ready;
    logic [2:0]        tl_a_opcode;
    logic [1:0]        tl_a_size;
    logic [SRC_W-1:0]  tl_a_source;
    logic [ADDR_W-1:0] tl_a_address;
    logic [3:0]        tl_a_mask;
    logic [31:0]       tl_a_data;
    logic              tl_d_valid;
    logic              tl_d_ready;
    logic [2:0]        tl_d_opcode;
    logic [1:0]        tl_d_size;
    logic [SRC_W-1:0]  tl_d_source;
    logic [31:0]       tl_d_data;
    logic              tl_d_error;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [1:0]        HTRANS;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADY;
    logic              HRESP;

    modport slave (
        input  tl_a_valid, tl_a_opcode, tl_a_size, tl_a_source, tl_a_address, tl_a_mask, tl_a_data,
        input  tl_d_ready, HRDATA, HREADY, HRESP,
        output tl_a_ready, tl_d_valid, tl_d_opcode, tl_d_size, tl_d_source, tl_d_data, tl_d_error,
        output HADDR, HWRITE, HSIZE, HTRANS, HWDATA
    );

    modport master (
        output tl_a_valid, tl_a_opcode, tl_a_size, tl_a_source, tl_a_address, tl_a_mask, tl_a_data,
        output tl_d_ready, HRDATA, HREADY, HRESP,
        input  tl_a_ready, tl_d_valid, tl_d_opcode, tl_d_size, tl_d_source, tl_d_data, tl_d_error,
        input  HADDR, HWRITE, HSIZE, HTRANS, HWDATA
    );
endinterface

// File: rtl/tl_ahb_req_check.sv
// Combinational legality check of a TL-UL request and derivation of its AHB address-phase fields.
module tl_ahb_req_check
    import tl_ahb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [2:0]        opcode,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] address,
    input  logic [3:0]        mask,
    output logic              legal,
    output logic [ADDR_W-1:0] haddr,
    output logic [2:0]        hsize,
    output logic              hwrite,
    output logic              is_get
);
    mask_decode_t md;
    logic         aligned;
    logic         op_ok;

    always_comb begin
        md      = mask_to_size(mask);
        aligned = 1'b0;
        op_ok   = 1'b0;
        haddr   = address;
        hsize   = {1'b0, size};
        hwrite  = 1'b0;
        is_get  = 1'b0;

        // size 3 is never aligned, which also rejects over-wide requests
        case (size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = (address[0] == 1'b0);
            2'd2:    aligned = (address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase

        case (opcode)
            TL_GET: begin
                op_ok  = 1'b1;
                is_get = 1'b1;
            end
            TL_PUT_FULL: begin
                op_ok  = 1'b1;
                hwrite = 1'b1;
            end
            TL_PUT_PARTIAL: begin
                op_ok  = md.legal;
                hwrite = 1'b1;
                hsize  = md.size;
                haddr  = {address[ADDR_W-1:2], md.lo};
            end
            default: op_ok = 1'b0;
        endcase

        legal = op_ok && aligned;
    end
endmodule

// File: rtl/tl_to_ahb_bridge.sv
// TL-UL slave to AHB-Lite master bridge: one outstanding request, one NONSEQ transfer each,
// result returned on the TL D channel. All outputs come straight from registers.
module tl_to_ahb_bridge
    import tl_ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SRC_W  = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    tl_to_ahb_bridge_if.slave bus
);
    bridge_state_e     state_reg, state_next;
    logic              a_ready_reg, a_ready_next;
    logic              d_valid_reg, d_valid_next;
    logic [2:0]        d_opcode_reg, d_opcode_next;
    logic [1:0]        d_size_reg, d_size_next;
    logic [SRC_W-1:0]  d_source_reg, d_source_next;
    logic [31:0]       d_data_reg, d_data_next;
    logic              d_error_reg, d_error_next;
    logic [ADDR_W-1:0] haddr_reg, haddr_next;
    logic              hwrite_reg, hwrite_next;
    logic [2:0]        hsize_reg, hsize_next;
    logic [1:0]        htrans_reg, htrans_next;
    logic [31:0]       hwdata_reg, hwdata_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              is_get_reg, is_get_next;

    logic              chk_legal;
    logic [ADDR_W-1:0] chk_haddr;
    logic [2:0]        chk_hsize;
    logic              chk_hwrite;
    logic              chk_is_get;
    logic              accept;

    tl_ahb_req_check #(.ADDR_W(ADDR_W)) u_req_check (
        .opcode  (bus.tl_a_opcode),
        .size    (bus.tl_a_size),
        .address (bus.tl_a_address),
        .mask    (bus.tl_a_mask),
        .legal   (chk_legal),
        .haddr   (chk_haddr),
        .hsize   (chk_hsize),
        .hwrite  (chk_hwrite),
        .is_get  (chk_is_get)
    );

    assign accept = (state_reg == ST_IDLE) && a_ready_reg && bus.tl_a_valid;

    always_comb begin
        state_next    = state_reg;
        a_ready_next  = a_ready_reg;
        d_valid_next  = d_valid_reg;
        d_opcode_next = d_opcode_reg;
        d_size_next   = d_size_reg;
        d_source_next = d_source_reg;
        d_data_next   = d_data_reg;
        d_error_next  = d_error_reg;
        haddr_next    = haddr_reg;
        hwrite_next   = hwrite_reg;
        hsize_next    = hsize_reg;
        htrans_next   = htrans_reg;
        hwdata_next   = hwdata_reg;
        wdata_next    = wdata_reg;
        is_get_next   = is_get_reg;

        case (state_reg)
            ST_IDLE: begin
                a_ready_next = 1'b1;
                if (accept) begin
                    a_ready_next  = 1'b0;
                    is_get_next   = chk_is_get;
                    wdata_next    = bus.tl_a_data;
                    d_opcode_next = chk_is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
                    d_size_next   = bus.tl_a_size;
                    d_source_next = bus.tl_a_source;
                    d_data_next   = 32'h0;
                    if (chk_legal) begin
                        state_next   = ST_ADDR;
                        d_error_next = 1'b0;
                        haddr_next   = chk_haddr;
                        hsize_next   = chk_hsize;
                        hwrite_next  = chk_hwrite;
                        htrans_next  = HTRANS_NONSEQ;
                    end else begin
                        // rejected requests never reach the AHB side
                        state_next   = ST_RESP;
                        d_error_next = 1'b1;
                        d_valid_next = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (bus.HREADY) begin
                    state_next  = ST_DATA;
                    htrans_next = HTRANS_IDLE;
                    if (hwrite_reg) begin
                        hwdata_next = wdata_reg;
                    end
                end
            end
            ST_DATA: begin
                // HRESP only counts on the completing beat; the first error cycle is a wait
                if (bus.HREADY) begin
                    state_next   = ST_RESP;
                    d_valid_next = 1'b1;
                    d_error_next = bus.HRESP;
                    d_data_next  = (is_get_reg && !bus.HRESP) ? bus.HRDATA : 32'h0;
                end
            end
            ST_RESP: begin
                if (bus.tl_d_ready) begin
                    state_next   = ST_IDLE;
                    d_valid_next = 1'b0;
                    a_ready_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg    <= ST_IDLE;
            a_ready_reg  <= 1'b0;
            d_valid_reg  <= 1'b0;
            d_opcode_reg <= 3'd0;
            d_size_reg   <= 2'd0;
            d_source_reg <= '0;
            d_data_reg   <= 32'h0;
            d_error_reg  <= 1'b0;
            haddr_reg    <= '0;
            hwrite_reg   <= 1'b0;
            hsize_reg    <= 3'd0;
            htrans_reg   <= HTRANS_IDLE;
            hwdata_reg   <= 32'h0;
            wdata_reg    <= 32'h0;
            is_get_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            a_ready_reg  <= a_ready_next;
            d_valid_reg  <= d_valid_next;
            d_opcode_reg <= d_opcode_next;
            d_size_reg   <= d_size_next;
            d_source_reg <= d_source_next;
            d_data_reg   <= d_data_next;
            d_error_reg  <= d_error_next;
            haddr_reg    <= haddr_next;
            hwrite_reg   <= hwrite_next;
            hsize_reg    <= hsize_next;
            htrans_reg   <= htrans_next;
            hwdata_reg   <= hwdata_next;
            wdata_reg    <= wdata_next;
            is_get_reg   <= is_get_next;
        end
    end

    assign bus.tl_a_ready  = a_ready_reg;
    assign bus.tl_d_valid  = d_valid_reg;
    assign bus.tl_d_opcode = d_opcode_reg;
    assign bus.tl_d_size   = d_size_reg;
    assign bus.tl_d_source = d_source_reg;
    assign bus.tl_d_data   = d_data_reg;
    assign bus.tl_d_error  = d_error_reg;
    assign bus.HADDR       = haddr_reg;
    assign bus.HWRITE      = hwrite_reg;
    assign bus.HSIZE       = hsize_reg;
    assign bus.HTRANS      = htrans_reg;
    assign bus.HWDATA      = hwdata_reg;
endmodule

// File: tb/tb_tl_to_ahb_bridge.sv
// Randomised and directed bench for tl_to_ahb_bridge with an AHB slave and a request-rule model.
module tb_tl_to_ahb_bridge;
    localparam int ADDR_W = 32;
    localparam int SRC_W  = 4;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    tl_to_ahb_bridge_if #(.ADDR_W(ADDR_W), .SRC_W(SRC_W)) bus ();

    tl_to_ahb_bridge #(.ADDR_W(ADDR_W), .SRC_W(SRC_W)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Request rules: partial masks must be one naturally aligned power-of-two lane group.
    task automatic model(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                         input logic [3:0] mask, output bit legal, output logic [31:0] haddr,
                         output logic [2:0] hsize, output bit hwrite);
        int ones;
        int low;
        bit op_ok;
        bit mask_ok;
        op_ok  = (op == 3'd4) || (op == 3'd0) || (op == 3'd1);
        hwrite = (op != 3'd4);
        haddr  = addr;
        hsize  = {1'b0, size};
        ones   = $countones(mask);
        low    = 0;
        for (int i = 3; i >= 0; i--) if (mask[i]) low = i;
        mask_ok = 1'b1;
        if (op == 3'd1) begin
            mask_ok = (ones == 1 || ones == 2 || ones == 4) && (low % ones == 0)
                      && (mask == 4'(((1 << ones) - 1) << low));
            hsize   = (ones == 4) ? 3'd2 : (ones == 2) ? 3'd1 : 3'd0;
            haddr   = {addr[31:2], 2'(low)};
        end
        legal = op_ok && mask_ok && (size <= 2'd2) && ((addr % (32'd1 << size)) == 0);
    endtask

    task automatic do_txn(input logic [2:0] op, input logic [1:0] size, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data, input logic [3:0] src,
                          input logic [31:0] rdata, input int aw, input int dw, input bit err,
                          input int dly, input bit junk);
        bit legal, hwrite, done, in_data, go_data, d_seen, is_get, ready_busy;
        logic [31:0] e_haddr, o_haddr, o_hwdata, e_ddata, o_ddata;
        logic [2:0]  e_hsize, o_hsize, e_dop, o_dop;
        logic        o_hwrite, o_derr, e_derr;
        logic [1:0]  o_dsize;
        logic [3:0]  o_dsrc;
        int nonseq_cnt, nonseq_first, dlat, acnt, dcnt, e_lat, e_ncnt, wait_cnt;

        model(op, size, addr, mask, legal, e_haddr, e_hsize, hwrite);
        is_get  = (op == 3'd4);
        e_derr  = !legal || err;
        e_ddata = (legal && is_get && !err) ? rdata : 32'h0;
        e_dop   = is_get ? 3'd1 : 3'd0;
        e_lat   = legal ? 3 + aw + dw : 1;
        e_ncnt  = legal ? 1 + aw : 0;
        o_haddr = e_haddr;  o_hsize = e_hsize; o_hwrite = hwrite; o_hwdata = data;
        o_dop   = e_dop;    o_dsize = size;    o_dsrc = src;      o_ddata = e_ddata; o_derr = e_derr;
        done = 0; in_data = 0; d_seen = 0; ready_busy = 0;
        nonseq_cnt = 0; nonseq_first = -1; dlat = -1; acnt = 0; dcnt = 0;

        wait_cnt = 0;
        while (!bus.tl_a_ready && wait_cnt < 10) begin
            @(negedge HCLK);
            wait_cnt++;
        end
        check("a_ready_idle", bus.tl_a_ready, 1'b1);

        bus.tl_a_valid = 1'b1;  bus.tl_a_opcode = op;  bus.tl_a_size = size;
        bus.tl_a_address = addr; bus.tl_a_mask = mask; bus.tl_a_data = data; bus.tl_a_source = src;
        bus.tl_d_ready = (dly == 0);
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        @(posedge HCLK);

        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge HCLK);
            // observe the cycle
            if (bus.tl_a_ready) ready_busy = 1;
            if (bus.HTRANS == 2'b10) begin
                nonseq_cnt++;
                if (nonseq_first < 0) nonseq_first = c;
                if (bus.HADDR !== e_haddr) o_haddr = bus.HADDR;
                if (bus.HSIZE !== e_hsize) o_hsize = bus.HSIZE;
                if (bus.HWRITE !== hwrite) o_hwrite = bus.HWRITE;
            end
            if (in_data && hwrite && bus.HWDATA !== data) o_hwdata = bus.HWDATA;
            if (bus.tl_d_valid) begin
                if (!d_seen) begin
                    d_seen = 1;
                    dlat   = c;
                end
                if (bus.tl_d_opcode !== e_dop)   o_dop   = bus.tl_d_opcode;
                if (bus.tl_d_size   !== size)    o_dsize = bus.tl_d_size;
                if (bus.tl_d_source !== src)     o_dsrc  = bus.tl_d_source;
                if (bus.tl_d_data   !== e_ddata) o_ddata = bus.tl_d_data;
                if (bus.tl_d_error  !== e_derr)  o_derr  = bus.tl_d_error;
            end
            // requests offered while busy must be ignored
            if (junk && !d_seen) begin
                bus.tl_a_valid = 1'b1;
                bus.tl_a_address = $urandom;
                bus.tl_a_opcode = 3'($urandom_range(0, 7));
            end else begin
                bus.tl_a_valid = 1'b0;
            end
            // AHB slave
            go_data = 0;
            bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = ~rdata;
            if (in_data) begin
                if (dcnt < dw) begin
                    bus.HREADY = 1'b0;
                    bus.HRESP  = err && (dcnt == dw - 1);
                    dcnt++;
                end else begin
                    bus.HRDATA = rdata;
                    bus.HRESP  = err;
                    in_data    = 0;
                end
            end else if (bus.HTRANS == 2'b10) begin
                if (acnt < aw) begin
                    bus.HREADY = 1'b0;
                    acnt++;
                end else begin
                    go_data = 1;
                end
            end
            if (go_data) in_data = 1;
            if (d_seen) begin
                bus.tl_d_ready = (c - dlat >= dly);
                if (bus.tl_d_ready) done = 1;
            end
        end

        check("d_handshake", done, 1'b1);
        check("nonseq_cycles", nonseq_cnt, e_ncnt);
        check("d_latency", dlat, e_lat);
        check("a_ready_busy", ready_busy, 1'b0);
        if (legal) begin
            check("nonseq_start", nonseq_first, 1);
            check("haddr", o_haddr, e_haddr);
            check("hsize", o_hsize, e_hsize);
            check("hwrite", o_hwrite, hwrite);
            if (hwrite) check("hwdata", o_hwdata, data);
        end
        check("d_opcode", o_dop, e_dop);
        check("d_size", o_dsize, size);
        check("d_source", o_dsrc, src);
        check("d_data", o_ddata, e_ddata);
        check("d_error", o_derr, e_derr);
        if (done) begin
            @(negedge HCLK);
            bus.tl_d_ready = 1'b0;
            check("a_ready_after", bus.tl_a_ready, 1'b1);
        end
        n_txn++;
        $display("[TB] txn %0d op=%0d size=%0d addr=%h mask=%h aw=%0d dw=%0d err=%0d dly=%0d -> legal=%0d lat=%0d d_err=%0d d_data=%h",
                 n_txn, op, size, addr, mask, aw, dw, err, dly, legal, dlat, o_derr, o_ddata);
    endtask

    initial begin
        logic [3:0]  lmasks [7];
        logic [2:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  mask;
        int          r, dw;
        bit          err;

        lmasks = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
        bus.tl_a_valid = 1'b0; bus.tl_a_opcode = 3'd0; bus.tl_a_size = 2'd0; bus.tl_a_source = '0;
        bus.tl_a_address = '0; bus.tl_a_mask = 4'h0; bus.tl_a_data = 32'h0; bus.tl_d_ready = 1'b0;
        bus.HRDATA = 32'h0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;

        // reset values
        repeat (2) @(negedge HCLK);
        check("rst_a_ready", bus.tl_a_ready, 1'b0);
        check("rst_d_valid", bus.tl_d_valid, 1'b0);
        check("rst_htrans", bus.HTRANS, 2'b00);
        check("rst_haddr", bus.HADDR, 32'h0);
        check("rst_hwdata", bus.HWDATA, 32'h0);
        check("rst_d_fields", {bus.tl_d_opcode, bus.tl_d_size, bus.tl_d_source, bus.tl_d_data, bus.tl_d_error}, 0);
        HRESET = 1'b0;
        @(negedge HCLK);
        check("rel_a_ready", bus.tl_a_ready, 1'b1);

        // directed scenarios
        do_txn(3'd4, 2'd2, 32'h4000_0010, 4'hF, 32'h0, 4'd3, 32'hDEAD_BEEF, 0, 0, 1'b0, 0, 1'b0);
        do_txn(3'd0, 2'd2, 32'h0000_0100, 4'hF, 32'hA5A5_5A5A, 4'd1, 32'h0, 0, 2, 1'b0, 0, 1'b0);
        do_txn(3'd1, 2'd2, 32'h0000_0200, 4'h4, 32'h1122_3344, 4'd2, 32'h0, 0, 0, 1'b0, 0, 1'b0);
        do_txn(3'd1, 2'd2, 32'h0000_0200, 4'hC, 32'h5566_7788, 4'd4, 32'h0, 0, 0, 1'b0, 0, 1'b0);
        do_txn(3'd1, 2'd2, 32'h0000_0200, 4'h5, 32'h99AA_BBCC, 4'd5, 32'h0, 0, 0, 1'b0, 0, 1'b0);
        do_txn(3'd4, 2'd2, 32'h0000_0040, 4'hF, 32'h0, 4'd6, 32'hCAFE_F00D, 0, 1, 1'b1, 0, 1'b0);
        do_txn(3'd4, 2'd2, 32'h0000_0080, 4'hF, 32'h0, 4'd7, 32'h1234_5678, 1, 0, 1'b0, 4, 1'b1);

        // reset during the address phase
        @(negedge HCLK);
        bus.tl_a_valid = 1'b1; bus.tl_a_opcode = 3'd4; bus.tl_a_size = 2'd2;
        bus.tl_a_address = 32'h0000_0300; bus.tl_a_source = 4'd9; bus.HREADY = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        bus.tl_a_valid = 1'b0;
        check("mid_nonseq", bus.HTRANS, 2'b10);
        HRESET = 1'b1;
        #1;
        check("mid_rst_htrans", bus.HTRANS, 2'b00);
        check("mid_rst_d_valid", bus.tl_d_valid, 1'b0);
        check("mid_rst_haddr", bus.HADDR, 32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        check("mid_rel_a_ready", bus.tl_a_ready, 1'b1);
        check("mid_rel_d_valid", bus.tl_d_valid, 1'b0);

        // randomised traffic
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      op = 3'd4;
            else if (r < 6) op = 3'd0;
            else if (r < 9) op = 3'd1;
            else begin
                r  = $urandom_range(0, 4);
                op = (r == 0) ? 3'd2 : (r == 1) ? 3'd3 : (r == 2) ? 3'd5 : (r == 3) ? 3'd6 : 3'd7;
            end
            size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
            mask = ($urandom_range(0, 3) != 0) ? lmasks[$urandom_range(0, 6)] : 4'($urandom_range(0, 15));
            err  = ($urandom_range(0, 3) == 0);
            dw   = $urandom_range(0, 3);
            if (err && dw == 0) dw = 1;
            do_txn(op, size, addr, mask, $urandom, 4'($urandom_range(0, 15)), $urandom,
                   $urandom_range(0, 2), dw, err, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tl_to_ahb_bridge.md
Name: tl_to_ahb_bridge

Overview:
TileLink-UL (TL-UL) slave to AHB-Lite master bridge. It accepts one TL A-channel request at a time and issues a single AHB-Lite NONSEQ transfer. When the AHB data phase completes, it returns the result on the TL D channel. It sits between a TL-UL crossbar port and a legacy AHB-Lite peripheral segment, and is the inverse of the team's AHB-to-TL bridge.

Parameters:
ADDR_W, 32, address width on both the TL and AHB sides
SRC_W, 4, width of the TL source ID, echoed from a_source to d_source
Data width is fixed at 32 bits; the mask is 4 bits.

Ports:
HCLK  in  1  clock
HRESET  in  1  asynchronous, active-high reset
tl_a_valid  in  1  A-channel request valid
tl_a_ready  out  1  A-channel request accept
tl_a_opcode  in  3  Get / PutFullData / PutPartialData
tl_a_size  in  2  log2 of bytes (0..2)
tl_a_source  in  SRC_W  request ID
tl_a_address  in  ADDR_W  byte address
tl_a_mask  in  4  byte lanes
tl_a_data  in  32  write data
tl_d_valid  out  1  D-channel response valid
tl_d_ready  in  1  D-channel response accept
tl_d_opcode  out  3  AccessAck / AccessAckData
tl_d_size  out  2  echo of the request size
tl_d_source  out  SRC_W  echo of the request source
tl_d_data  out  32  read data (0 for writes)
tl_d_error  out  1  error flag
HADDR  out  ADDR_W  AHB address
HWRITE  out  1  AHB write
HSIZE  out  3  AHB transfer size
HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only
HWDATA  out  32  AHB write data
HRDATA  in  32  AHB read data
HREADY  in  1  AHB ready
HRESP  in  1  AHB error response

Behaviour:
- Reset values: tl_a_ready=0, tl_d_valid=0, all tl_d_* fields=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, state=IDLE.
- Reset asserted mid-operation aborts the transaction with no D response and returns HTRANS to IDLE asynchronously.
- All outputs are registered. tl_a_ready=1 only in the IDLE state, so at most one transaction is outstanding.
- FSM states:
  - IDLE: on tl_a_valid && tl_a_ready, latch opcode, size, source, address, mask and data, then run the legality check.
    - Legal request -> ADDR.
    - Illegal request -> RESP with d_error=1 and no AHB transfer.
  - ADDR: HTRANS=NONSEQ. HADDR, HWRITE and HSIZE come from the latched request. On HREADY=1 -> DATA, with HTRANS=IDLE from the next cycle. On HREADY=0, hold all address-phase signals stable.
  - DATA: HWDATA=latched data for writes. Wait for HREADY=1, then capture HRDATA (reads) and HRESP into d_error -> RESP.
    - The first error cycle (HREADY=0, HRESP=1) is only a wait cycle; HRESP is sampled only when HREADY=1.
  - RESP: tl_d_valid=1 with all fields held stable until tl_d_ready=1, then -> IDLE.
- Response opcodes: Get -> AccessAckData (3'd1). Puts -> AccessAck (3'd0). Errored Get returns d_data=0.
- HSIZE derivation:
  - Get and PutFullData use HSIZE = a_size.
  - PutPartialData derives HSIZE from the mask: 4'hF -> word; 4'h3 or 4'hC -> half; single-bit mask -> byte. HADDR[1:0] is set to the lowest set mask lane.
- Illegal requests:
  - any other PutPartialData mask;
  - a_size > 2;
  - an address misaligned to a_size;
  - an unknown opcode.
- Minimum latency with HREADY held at 1: A handshake at edge N, NONSEQ during cycle N+1, data phase during N+2, tl_d_valid=1 from N+3. Each HREADY=0 cycle adds one cycle.
- Back-to-back: tl_a_ready reasserts in the cycle after the D handshake, giving 4 cycles per transaction minimum.
- tl_d_ready held at 1 before d_valid has no effect. tl_a_valid asserted outside IDLE is ignored (a_ready=0).

Decomposition:
- Package tl_ahb_pkg:
  - TL opcode constants: Get=3'd4, PutFullData=3'd0, PutPartialData=3'd1, AccessAck=3'd0, AccessAckData=3'd1.
  - HTRANS constants.
  - HSIZE encodings.
  - The bridge state enum.
  - A mask_to_size function returning legal, size and low address bits.
- One sub-module: tl_ahb_req_check, combinational legality check and HSIZE/HADDR derivation, unit-testable on its own.

Test Plan:
- Read with HREADY=1: Get at 0x4000_0010, size 2, source 3; slave HRDATA=0xDEADBEEF -> HTRANS=NONSEQ one cycle later. Then d_valid with opcode=1, data=0xDEADBEEF, source=3, error=0, 3 cycles after acceptance.
- Write with wait states: PutFullData to 0x100, data 0xA5A5_5A5A; slave holds HREADY=0 for 2 data-phase cycles -> HWDATA stable throughout, HWRITE=1 in the address phase, AccessAck arrives 5 cycles after acceptance.
- Partial writes:
  - mask 4'h4 at 0x200 -> HADDR=0x202, HSIZE=0;
  - mask 4'hC -> HADDR=0x202, HSIZE=1;
  - mask 4'h5 -> d_error=1 with no NONSEQ ever driven.
- AHB error: Get, slave returns HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> single D response with error=1 and data=0.
- D backpressure and reset: tl_d_ready=0 for 4 cycles -> d fields stable and a_ready=0. Then assert HRESET during ADDR on a new request -> HTRANS=IDLE, d_valid=0 immediately; after release, a_ready=1 in the first cycle.
